// File: rtl/seq_pkg.sv
// Shared constants for the instruction sequencer: opcodes, FSM state encoding,
// register one-hot selects and the decoded instruction class.
package seq_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    DECODE   = 4'd1,
    EXEC     = 4'd2,
    ALU_A    = 4'd3,
    ALU_B    = 4'd4,
    ALU_WAIT = 4'd5,
    WB       = 4'd6,
    DONE     = 4'd7,
    HALT     = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    CLS_NOP  = 2'd0,
    CLS_MOVI = 2'd1,
    CLS_MOV  = 2'd2,
    CLS_ALU  = 2'd3
  } cls_t;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_MOVI = 4'b0111;

  localparam logic [4:0] REG_G0 = 5'b00001;
  localparam logic [4:0] REG_G1 = 5'b00010;
  localparam logic [4:0] REG_G2 = 5'b00100;
  localparam logic [4:0] REG_G3 = 5'b01000;
  localparam logic [4:0] REG_P0 = 5'b10000;
  localparam logic [2:0] REG_MAX = 3'd4;

  // Register index to one-hot enable; out-of-range indices select nothing.
  function automatic logic [4:0] reg_sel(input logic [2:0] idx);
    case (idx)
      3'd0:    reg_sel = REG_G0;
      3'd1:    reg_sel = REG_G1;
      3'd2:    reg_sel = REG_G2;
      3'd3:    reg_sel = REG_G3;
      3'd4:    reg_sel = REG_P0;
      default: reg_sel = 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Instruction field check: classifies the opcode and flags illegal opcodes
// or register indices outside G0..G3/P0.
module instr_decode
  import seq_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [2:0] dst,
  input  logic [2:0] src,
  output cls_t       cls,
  output logic       legal,
  output logic       is_sub
);

  logic known;
  logic uses_src;

  always_comb begin
    cls      = CLS_NOP;
    known    = 1'b1;
    uses_src = 1'b0;
    case (opcode)
      OP_NOP:  cls = CLS_NOP;
      OP_MOVI: cls = CLS_MOVI;
      OP_MOV: begin
        cls      = CLS_MOV;
        uses_src = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        cls      = CLS_ALU;
        uses_src = 1'b1;
      end
      default: known = 1'b0;
    endcase
  end

  // MOVI reuses the src field as immediate bits, so src is only checked when it names a register.
  assign legal  = known && (dst <= REG_MAX) && !(uses_src && (src > REG_MAX));
  assign is_sub = (opcode == OP_SUB);

endmodule

// File: rtl/instr_sequencer.sv
// Micro-sequencer driving register/ALU bus enables for NOP/MOV/MOVI/ADD/SUB.
// Optional build macro ILLEGAL_TRAP_EN: illegal instructions set a sticky trap and halt.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int ALU_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [4:0]  reg_in,
  output logic [4:0]  reg_out,
  output logic        imm_out,
  output logic [15:0] imm_value,
  output logic        alu_a_ld,
  output logic        alu_start,
  output logic        alu_sub,
  output logic        alu_res_out,
  input  logic        alu_done,
  output logic        PC_inc,
  output logic        done,
  output logic        err,
`ifdef ILLEGAL_TRAP_EN
  output logic        trap,
`endif
  output state_t      seq_state
);

  localparam int CW = $clog2(ALU_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ALU_TIMEOUT - 1);

  state_t        state;
  state_t        next;
  logic [15:0]   ir;
  logic [CW-1:0] cnt;
  cls_t          cls;
  logic          legal;
  logic          is_sub;
  logic          accept;
  logic          timeout;

  // Handshake: instr is taken in a cycle where instr_valid and instr_ready are both high;
  // instr_ready is high only in IDLE with reset released.
  assign instr_ready = (state == IDLE) && rst;
  assign accept      = instr_valid && instr_ready;
  assign timeout     = (state == ALU_WAIT) && !alu_done && (cnt == CNT_LAST);
  assign seq_state   = state;

  instr_decode u_decode (
    .opcode (ir[15:12]),
    .dst    (ir[11:9]),
    .src    (ir[8:6]),
    .cls    (cls),
    .legal  (legal),
    .is_sub (is_sub)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        ir <= '0;
    else if (accept) ir <= instr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    cnt <= '0;
    else if (state == ALU_WAIT)  cnt <= cnt + 1'b1;
    else                         cnt <= '0;
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           trap <= 1'b0;
    else if (state == DECODE && !legal) trap <= 1'b1;
  end
`endif

  always_comb begin
    next = state;
    case (state)
      IDLE: if (accept) next = DECODE;
      DECODE: begin
        if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
          next = HALT;
`else
          next = DONE;
`endif
        end else begin
          case (cls)
            CLS_NOP:           next = DONE;
            CLS_MOVI, CLS_MOV: next = EXEC;
            default:           next = ALU_A;
          endcase
        end
      end
      EXEC:     next = DONE;
      ALU_A:    next = ALU_B;
      ALU_B:    next = ALU_WAIT;
      ALU_WAIT: begin
        if (alu_done)              next = WB;
        else if (cnt == CNT_LAST)  next = DONE;
      end
      WB:       next = DONE;
      DONE:     next = IDLE;
      HALT:     next = HALT;
      default:  next = IDLE;
    endcase
  end

  always_comb begin
    reg_in      = 5'b00000;
    reg_out     = 5'b00000;
    imm_out     = 1'b0;
    imm_value   = 16'h0000;
    alu_a_ld    = 1'b0;
    alu_start   = 1'b0;
    alu_sub     = 1'b0;
    alu_res_out = 1'b0;
    PC_inc      = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      DECODE: err = !legal;
      EXEC: begin
        reg_in = reg_sel(ir[11:9]);
        if (cls == CLS_MOVI) begin
          imm_out   = 1'b1;
          imm_value = {7'b0, ir[8:0]};
        end else begin
          reg_out = reg_sel(ir[8:6]);
        end
      end
      ALU_A: begin
        reg_out  = reg_sel(ir[11:9]);
        alu_a_ld = 1'b1;
      end
      ALU_B: begin
        reg_out   = reg_sel(ir[8:6]);
        alu_start = 1'b1;
        alu_sub   = is_sub;
      end
      ALU_WAIT: begin
        alu_sub = is_sub;
        err     = timeout;
      end
      WB: begin
        alu_res_out = 1'b1;
        reg_in      = reg_sel(ir[11:9]);
      end
      DONE: begin
        done   = 1'b1;
        PC_inc = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
